conversor_bcd_duplo: RTL and testbench
======================================

Name: conversor_bcd_duplo

Overview:
- Sequential signed-binary to sign/tens/units converter. Uses shift-and-add-3 (double dabble), one shift per clock.
- Sits directly upstream of the two-digit seven-segment decoder and drives its sinal, dezena and unidade inputs.
- Converts one value per start request and holds the result until the next conversion completes.
- Values outside -99..99 are presented as dash-dash ("--").

Parameters:
- WIDTH, 8, width of the two's-complement input. Legal range is 5..10; the internal BCD register is 12 bits.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- inicio  input  1  start request; sampled only while idle
- valor  input  WIDTH  signed two's-complement value; captured on the accepting edge
- ocupado  output  1  conversion in progress
- pronto  output  1  one-cycle pulse when new results are valid
- sinal  output  1  1 = negative value
- dezena  output  4  tens digit: BCD 0..9, 4'hF = dash, 4'hA = blank
- unidade  output  4  units digit: BCD 0..9, 4'hF = dash

Behaviour:
- Reset state:
  - Reset is synchronous and active-high.
  - Reset values: ocupado=0, pronto=0, sinal=0, dezena=4'h0, unidade=4'h0. These hold regardless of the optional macro.
  - FSM enters OCIOSO.
- FSM states: OCIOSO, CONVERTE, FINALIZA.
- OCIOSO:
  - If inicio=1 at edge E0:
    - Capture sign = valor[WIDTH-1].
    - Compute magnitude = |valor| into a WIDTH-bit unsigned register. For the most negative value this gives 2^(WIDTH-1), with no wrap.
    - Clear the 12-bit BCD register, load shift counter = WIDTH, go to CONVERTE.
  - inicio=0: stay.
- CONVERTE:
  - At each edge: add 3 to every BCD nibble >= 5, then shift {bcd, magnitude} left by one and decrement the counter.
  - After exactly WIDTH shifts (edges E1..E_WIDTH), go to FINALIZA.
- FINALIZA:
  - At edge E_(WIDTH+1), register the outputs:
    - sinal = captured sign.
    - If hundreds nibble != 0: dezena=4'hF, unidade=4'hF (overflow).
    - Otherwise: dezena = tens nibble, unidade = units nibble.
  - At the same edge: set pronto=1 and return to OCIOSO.
- Timing:
  - ocupado=1 from after E0 through before E_(WIDTH+1): WIDTH+1 cycles.
  - pronto=1 for exactly the one cycle after E_(WIDTH+1), and only then. ocupado=0 in that cycle.
  - Latency from the accepting edge to visible results is WIDTH+1 edges (9 for WIDTH=8).
- Output stability:
  - sinal, dezena and unidade change only at the FINALIZA edge or on reset.
  - During conversion they hold the previous result, so the display never flickers.
- Boundary conditions:
  - inicio while ocupado=1: ignored, not queued. valor changes while busy: no effect.
  - inicio=1 during the pronto cycle: accepted, since the FSM is idle. Back-to-back conversions are therefore possible every WIDTH+2 cycles.
  - inicio held high continuously: converts repeatedly with the same cadence.
  - Zero: sinal=0, dezena=0, unidade=0.
  - Reset asserted mid-conversion: abort immediately. All outputs go to their reset values, no pronto pulse, FSM in OCIOSO.
  - Reset and inicio in the same cycle: reset wins.

Optional Feature:
- Macro: CONVERSOR_BCD_ZERO_BLANK_EN.
- Defined: for a non-overflow result with magnitude < 10, dezena = 4'hA (blank) instead of 4'h0.
  - The sign remains on sinal.
  - Reset value is unchanged (4'h0).
- Undefined: tens digit is always shown, including a leading zero.

Test Plan:
- valor=37, inicio pulse -> 9 cycles later pronto=1 for one cycle; sinal=0, dezena=3, unidade=7. ocupado high for 9 cycles.
- valor=-45 (8'hD3) -> sinal=1, dezena=4, unidade=5. valor=99 -> 0,9,9. valor=0 -> 0,0,0.
- valor=100 -> sinal=0, dezena=F, unidade=F. valor=-128 (8'h80) -> sinal=1, dezena=F, unidade=F.
- valor=5: without macro -> 0,0,5; with CONVERSOR_BCD_ZERO_BLANK_EN -> 0,A,5. valor=-7 with macro -> 1,A,7.
- Start 37, then pulse inicio with valor=12 at cycle 3 -> result 37 only, no second pronto. inicio during the pronto cycle with 12 -> second pronto 10 cycles after the first, result 1,2.
- Convert 37, then start 64 and assert reset at cycle 4 -> no pronto; outputs 0,0,0; ocupado=0. A fresh start with 64 then yields 0,6,4.

Source files
------------

// File: rtl/conversor_bcd_duplo.sv
// Signed binary to sign/tens/units converter (double dabble, one shift per clock).
// Optional macro CONVERSOR_BCD_ZERO_BLANK_EN blanks a leading zero in the tens digit.
module conversor_bcd_duplo #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inicio,
   input  logic [WIDTH-1:0] valor,
   output logic             ocupado,
   output logic             pronto,
   output logic             sinal,
   output logic [3:0]       dezena,
   output logic [3:0]       unidade
);

   typedef enum logic [1:0] {OCIOSO, CONVERTE, FINALIZA} estado_t;

   localparam int CW = $clog2(WIDTH + 1);

   estado_t          estado, prox;
   logic [CW-1:0]    cont;
   logic [WIDTH-1:0] mag;
   logic [11:0]      bcd, bcd_adj;
   logic             sinal_cap;
   logic [3:0]       dez_nova;

   always_ff @(posedge clock) begin
      if (reset) estado <= OCIOSO;
      else       estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:   if (inicio) prox = CONVERTE;
         CONVERTE: if (cont == CW'(1)) prox = FINALIZA;
         FINALIZA: prox = OCIOSO;
         default:  prox = OCIOSO;
      endcase
   end

   // add-3 correction applied before every shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++)
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
   assign dez_nova = (bcd[7:4] == 4'd0) ? 4'hA : bcd[7:4];
`else
   assign dez_nova = bcd[7:4];
`endif

   assign ocupado = (estado != OCIOSO);

   // sinal/dezena/unidade only move at FINALIZA so the display never flickers
   always_ff @(posedge clock) begin
      if (reset) begin
         sinal_cap <= 1'b0;
         mag       <= '0;
         bcd       <= '0;
         cont      <= '0;
         pronto    <= 1'b0;
         sinal     <= 1'b0;
         dezena    <= 4'h0;
         unidade   <= 4'h0;
      end else begin
         pronto <= 1'b0;
         case (estado)
            OCIOSO: if (inicio) begin
               sinal_cap <= valor[WIDTH-1];
               mag       <= valor[WIDTH-1] ? (~valor + 1'b1) : valor;
               bcd       <= '0;
               cont      <= CW'(WIDTH);
            end
            CONVERTE: begin
               {bcd, mag} <= {bcd_adj[10:0], mag, 1'b0};
               cont       <= cont - 1'b1;
            end
            FINALIZA: begin
               pronto <= 1'b1;
               sinal  <= sinal_cap;
               if (bcd[11:8] != 4'd0) begin
                  dezena  <= 4'hF;
                  unidade <= 4'hF;
               end else begin
                  dezena  <= dez_nova;
                  unidade <= bcd[3:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conversor_bcd_duplo.sv
// Randomized and directed bench for conversor_bcd_duplo against an arithmetic reference model.
module tb_conversor_bcd_duplo;
   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset, inicio;
   logic [W-1:0] valor;
   logic         ocupado, pronto, sinal;
   logic [3:0]   dezena, unidade;

   int n_chk  = 0;
   int n_fail = 0;

   logic       e_s;
   logic [3:0] e_d, e_u;

   conversor_bcd_duplo #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .inicio(inicio), .valor(valor),
      .ocupado(ocupado), .pronto(pronto), .sinal(sinal),
      .dezena(dezena), .unidade(unidade)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic void model(input logic [W-1:0] v, output logic s,
                                 output logic [3:0] d, output logic [3:0] u);
      int iv, m;
      iv = int'($signed(v));
      s  = (iv < 0);
      m  = s ? -iv : iv;
      if (m > 99) begin
         d = 4'hF;
         u = 4'hF;
      end else begin
         d = 4'(m / 10);
         u = 4'(m % 10);
`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
         if (m < 10) d = 4'hA;
`endif
      end
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Full cycle-accurate conversion; returns in the pronto cycle.
   // intr>0 pulses inicio with valor=junk at edge E_intr (must be ignored).
   task automatic start_conv(input logic [W-1:0] v, input int intr,
                             input logic [W-1:0] junk, input string nm);
      logic ns;
      logic [3:0] nd, nu;
      model(v, ns, nd, nu);
      inicio = 1'b1;
      valor  = v;
      tick;
      inicio = 1'b0;
      valor  = W'($urandom);
      n_chk++;
      if (ocupado !== 1'b1 || pronto !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_accept: got ocupado=%b pronto=%b, expected 1 0", nm, ocupado, pronto);
      end
      for (int k = 1; k <= W; k++) begin
         if (k == intr) begin
            inicio = 1'b1;
            valor  = junk;
         end
         tick;
         inicio = 1'b0;
         valor  = W'($urandom);
         n_chk++;
         if (ocupado !== 1'b1 || pronto !== 1'b0 || {sinal, dezena, unidade} !== {e_s, e_d, e_u}) begin
            n_fail++;
            $display("FAIL %s_busy%0d: got oc=%b pr=%b s=%b d=%h u=%h, expected oc=1 pr=0 s=%b d=%h u=%h",
                     nm, k, ocupado, pronto, sinal, dezena, unidade, e_s, e_d, e_u);
         end
      end
      tick;
      e_s = ns; e_d = nd; e_u = nu;
      n_chk++;
      if (ocupado !== 1'b0 || pronto !== 1'b1 || {sinal, dezena, unidade} !== {e_s, e_d, e_u}) begin
         n_fail++;
         $display("FAIL %s_result v=%0d: got oc=%b pr=%b s=%b d=%h u=%h, expected oc=0 pr=1 s=%b d=%h u=%h",
                  nm, $signed(v), ocupado, pronto, sinal, dezena, unidade, e_s, e_d, e_u);
      end
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      inicio = 1'b1;
      valor  = W'(37);
      tick;
      tick;
      n_chk++;
      if ({ocupado, pronto, sinal, dezena, unidade} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_state: got oc=%b pr=%b s=%b d=%h u=%h, expected all zero",
                  ocupado, pronto, sinal, dezena, unidade);
      end
      reset  = 1'b0;
      inicio = 1'b0;
      tick;
      n_chk++;
      if ({ocupado, pronto, sinal, dezena, unidade} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got oc=%b pr=%b s=%b d=%h u=%h, expected all zero",
                  ocupado, pronto, sinal, dezena, unidade);
      end
      e_s = 1'b0; e_d = 4'h0; e_u = 4'h0;
   endtask

   task automatic test_directed;
      int vals[14] = '{37, -45, 99, 0, 100, -128, 5, -7, 127, -99, -100, 10, -10, 9};
      foreach (vals[i]) begin
         start_conv(W'(vals[i]), 0, '0, "directed");
         tick;
         n_chk++;
         if (pronto !== 1'b0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_pulse: got pronto=%b ocupado=%b, expected 0 0", pronto, ocupado);
         end
      end
   endtask

   task automatic test_ignore_busy;
      start_conv(W'(37), 3, W'(12), "ignore");
      for (int c = 0; c < 12; c++) begin
         tick;
         n_chk++;
         if (pronto !== 1'b0 || ocupado !== 1'b0 || {sinal, dezena, unidade} !== {e_s, e_d, e_u}) begin
            n_fail++;
            $display("FAIL ignore_queued: got pr=%b oc=%b s=%b d=%h u=%h, expected pr=0 oc=0 s=%b d=%h u=%h",
                     pronto, ocupado, sinal, dezena, unidade, e_s, e_d, e_u);
         end
      end
   endtask

   task automatic test_back_to_back;
      start_conv(W'(37), 0, '0, "b2b_first");
      start_conv(W'(12), 0, '0, "b2b_second");
      tick;
      n_chk++;
      if (pronto !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_pulse: got pronto=%b, expected 0", pronto);
      end
   endtask

   task automatic test_reset_abort;
      start_conv(W'(37), 0, '0, "abort_pre");
      tick;
      inicio = 1'b1;
      valor  = W'(64);
      tick;
      inicio = 1'b0;
      for (int c = 0; c < 3; c++) tick;
      reset  = 1'b1;
      inicio = 1'b1;
      tick;
      n_chk++;
      if ({ocupado, pronto, sinal, dezena, unidade} !== 11'd0) begin
         n_fail++;
         $display("FAIL abort_reset: got oc=%b pr=%b s=%b d=%h u=%h, expected all zero",
                  ocupado, pronto, sinal, dezena, unidade);
      end
      reset  = 1'b0;
      inicio = 1'b0;
      e_s = 1'b0; e_d = 4'h0; e_u = 4'h0;
      for (int c = 0; c < 12; c++) begin
         tick;
         n_chk++;
         if ({ocupado, pronto, sinal, dezena, unidade} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort_quiet: got oc=%b pr=%b s=%b d=%h u=%h, expected all zero",
                     ocupado, pronto, sinal, dezena, unidade);
         end
      end
      start_conv(W'(64), 0, '0, "abort_fresh");
      tick;
   endtask

   task automatic test_held_inicio;
      logic [W-1:0] v;
      logic ns;
      logic [3:0] nd, nu;
      v = W'($urandom);
      model(v, ns, nd, nu);
      inicio = 1'b1;
      valor  = v;
      for (int c = 0; c < 40; c++) begin
         if (c == 39) inicio = 1'b0;
         tick;
         if (c == 39) inicio = 1'b0;
         n_chk++;
         if (pronto !== (c % 10 == 9) || ocupado !== (c % 10 != 9)) begin
            n_fail++;
            $display("FAIL held_cadence c=%0d: got pr=%b oc=%b, expected pr=%b oc=%b",
                     c, pronto, ocupado, (c % 10 == 9), (c % 10 != 9));
         end
         if (c % 10 == 9) begin
            e_s = ns; e_d = nd; e_u = nu;
            n_chk++;
            if ({sinal, dezena, unidade} !== {e_s, e_d, e_u}) begin
               n_fail++;
               $display("FAIL held_result v=%0d: got s=%b d=%h u=%h, expected s=%b d=%h u=%h",
                        $signed(v), sinal, dezena, unidade, e_s, e_d, e_u);
            end
         end
         if (c == 38) inicio = 1'b0;
      end
      tick;
      n_chk++;
      if (ocupado !== 1'b0 || pronto !== 1'b0) begin
         n_fail++;
         $display("FAIL held_stop: got oc=%b pr=%b, expected 0 0", ocupado, pronto);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         start_conv(W'($urandom), 0, '0, "random");
         repeat ($urandom_range(0, 2)) tick;
      end
      tick;
   endtask

   initial begin
      reset  = 1'b0;
      inicio = 1'b0;
      valor  = '0;
      e_s = 1'b0; e_d = 4'h0; e_u = 4'h0;
      tick;
      test_reset;
      test_directed;
      test_ignore_busy;
      test_back_to_back;
      test_reset_abort;
      test_held_inicio;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
